drive_pwm_sequencer: RTL
========================

Name: drive_pwm_sequencer

Overview:
- Parametrised successor to the line-follower drive block.
- Sits between the line-sensor direction decoder / tone-direction decoder and the dual H-bridge.
- Generates its own per-wheel PWM from duty words instead of consuming pre-built PWM lines.
- Adds soft-start ramping, a valid/ready junction command handshake, pausable timed turns, and a latched HALT state.

Parameters:
PWM_BITS, 8, width of duty words and of the free-running PWM counter
TURN_CYCLES, 25_000_000, clk cycles a junction pivot turn is driven
RAMP_STEP, 16, duty increment applied per ramp tick
RAMP_DIV, 50_000, clk cycles between ramp ticks (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
col_detect_n  in  1  0 = obstacle present
dir_control  in  4  [3:2]: 00 proceed, 01 left, 10 right, 11 junction; [1:0]: 01 veer, 10 hard, 11 pivot
duty_full  in  PWM_BITS  duty for straight / outer wheel
duty_veer  in  PWM_BITS  inner-wheel duty for veer and hard
duty_hard  in  PWM_BITS  outer-wheel duty for hard turns
duty_pivot_slow  in  PWM_BITS  inner-wheel duty for pivots
duty_pivot_fast  in  PWM_BITS  outer-wheel duty for pivots
jcmd  in  3  junction command: 0 straight, 1 left, 2 right, 3 back, 4 stop; 5-7 ignored
jcmd_valid  in  1  jcmd is valid
jcmd_ready  out  1  high only in JUNCTION/J_WAIT
tone_enable  out  1  enables tone detection
hb_in  out  4  H-bridge IN4..IN1
hb_en_a  out  1  right-wheel PWM enable
hb_en_b  out  1  left-wheel PWM enable
drive_state  out  2  0 DRIVE, 1 COLLISION, 2 JUNCTION, 3 HALT
direction  out  1  1 forwards, 0 reverse
turn_busy  out  1  high while a timed pivot is active

Behaviour:
- Reset values: all outputs 0, except direction = 1 and drive_state = DRIVE. Internal ramp duties, PWM counter and turn timer are cleared to 0. Reset wins over every other event.
- H-bridge patterns:
  - STRAIGHT 4'b0101, LEFT 4'b0110, RIGHT 4'b1001, STOP 4'b0000.
  - When direction = 0, STRAIGHT/LEFT/RIGHT are bitwise inverted; STOP is never inverted.
  - hb_in is registered, so a dir_control change is reflected at hb_in 1 cycle later.
- Targets (tgt_a = right wheel, tgt_b = left wheel) in DRIVE:
  - proceed [1:0]=00: full/full, STRAIGHT.
  - veer-left: veer/full, STRAIGHT. veer-right: full/veer, STRAIGHT.
  - hard-left: veer/hard, LEFT. hard-right: hard/veer, RIGHT.
  - pivot-left: slow/fast, LEFT. pivot-right: fast/slow, RIGHT.
  - proceed with [1:0]!=00: hold previous targets and pattern.
  - left/right with [1:0]=00: hold previous targets and pattern.
  - junction [3:2]=11: targets 0, STOP, move to JUNCTION/J_WAIT.
- Ramp:
  - Each wheel's actual duty moves toward its target by at most RAMP_STEP per tick; one tick every RAMP_DIV cycles.
  - Arithmetic saturates and never overshoots the target.
  - Decreases are immediate: if target < actual, actual = target on the next cycle.
  - In COLLISION and HALT, actual duties are forced to 0 on the next cycle.
- PWM:
  - Counter is free-running, PWM_BITS wide, and wraps.
  - hb_en_x = (cnt < actual_x), registered.
  - Duty 0 gives constant low; duty 2^PWM_BITS-1 gives low for 1 of 2^PWM_BITS cycles.
- COLLISION:
  - Entered from DRIVE or JUNCTION when col_detect_n = 0; the state being left is saved.
  - On col_detect_n = 1, return to the saved state and sub-state.
  - The turn timer is frozen, not cleared, so a paused pivot resumes for its remaining cycles.
  - tone_enable is forced to 0.
  - Collision asserted in HALT is ignored.
- JUNCTION sub-states:
  - J_WAIT: tone_enable = 1, jcmd_ready = 1. A transfer occurs when jcmd_valid & jcmd_ready & jcmd<=4; invalid codes are dropped with no state change. On transfer:
    - straight: go to DRIVE.
    - left/right: timer = 0, go to J_TURN with pivot targets and LEFT/RIGHT pattern.
    - back: toggle direction, go to DRIVE.
    - stop: go to HALT.
  - J_TURN: tone_enable = 0, turn_busy = 1, timer increments each cycle. When timer == TURN_CYCLES-1: timer = 0, go to DRIVE.
- HALT: targets 0, STOP pattern, jcmd_ready = 0. Left only by rst.
- Priority within a cycle: rst > collision > jcmd transfer / turn completion > dir_control.

Test Plan (PWM_BITS=4, TURN_CYCLES=20, RAMP_STEP=4, RAMP_DIV=2):
- Reset, then dir_control=0000, duty_full=12 → hb_in=0101 after 1 cycle; actual duty 0→4→8→12 at ticks 2/4/6 cycles; hb_en_a high 12 of 16 counts.
- Ramped to 12, then dir_control=0101 with duty_veer=3 → actual_a drops to 3 next cycle, actual_b stays 12, hb_in=0101.
- dir_control=1100, jcmd=1 valid 3 cycles later → jcmd_ready high only in J_WAIT; hb_in=0110; turn_busy high exactly 20 cycles; then drive_state=0.
- col_detect_n=0 for 7 cycles at turn cycle 10 → drive_state=1, hb_en_a=hb_en_b=0, tone_enable=0; after release turn_busy lasts 10 more cycles.
- jcmd=3 at junction → direction=0; dir_control=0000 → hb_in=1010. jcmd=6 is ignored and jcmd_ready stays high.
- jcmd=4 → drive_state=3; later col_detect_n=0 and dir_control changes → no change. rst=1 asserted mid-turn → all outputs reset next cycle.

Source files
------------

// File: rtl/drive_pwm_sequencer.sv
// Line-follower drive sequencer: per-wheel soft-start PWM, junction
// command handshake, pausable timed pivots and a latched halt.
module drive_pwm_sequencer #(
   parameter int PWM_BITS    = 8,
   parameter int TURN_CYCLES = 25_000_000,
   parameter int RAMP_STEP   = 16,
   parameter int RAMP_DIV    = 50_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                col_detect_n,
   input  logic [3:0]          dir_control,
   input  logic [PWM_BITS-1:0] duty_full,
   input  logic [PWM_BITS-1:0] duty_veer,
   input  logic [PWM_BITS-1:0] duty_hard,
   input  logic [PWM_BITS-1:0] duty_pivot_slow,
   input  logic [PWM_BITS-1:0] duty_pivot_fast,
   input  logic [2:0]          jcmd,
   input  logic                jcmd_valid,
   output logic                jcmd_ready,
   output logic                tone_enable,
   output logic [3:0]          hb_in,
   output logic                hb_en_a,
   output logic                hb_en_b,
   output logic [1:0]          drive_state,
   output logic                direction,
   output logic                turn_busy
);

   localparam int TW = $clog2(TURN_CYCLES + 1);
   localparam int RW = $clog2(RAMP_DIV + 1);
   localparam int SW = PWM_BITS + 1;
   localparam logic [SW-1:0] STEP = SW'(RAMP_STEP);

   typedef enum logic [1:0] {
      DRIVE     = 2'd0,
      COLLISION = 2'd1,
      JUNCTION  = 2'd2,
      HALT      = 2'd3
   } stateT;

   typedef enum logic [1:0] {
      P_STRAIGHT = 2'd0,
      P_LEFT     = 2'd1,
      P_RIGHT    = 2'd2,
      P_STOP     = 2'd3
   } patT;

   stateT               state, nextState;
   stateT               savedState, nextSaved;
   logic                inTurn, nextInTurn;
   logic [TW-1:0]       turnTimer, nextTimer;
   logic [PWM_BITS-1:0] tgtA, tgtB, nextTgtA, nextTgtB;
   patT                 pat, nextPat;
   logic                fwd, nextFwd;
   logic [PWM_BITS-1:0] actA, actB;
   logic [PWM_BITS-1:0] pwmCnt;
   logic [RW-1:0]       rampCnt;
   logic                rampTick;
   logic                killDuty;

   function automatic logic [PWM_BITS-1:0] rampTo(
      input logic [PWM_BITS-1:0] cur,
      input logic [PWM_BITS-1:0] tgt,
      input logic                tick
   );
      logic [PWM_BITS-1:0] gap;
      gap = tgt - cur;
      if (tgt <= cur)
         return tgt;
      else if (!tick)
         return cur;
      else if ({1'b0, gap} > STEP)
         return cur + STEP[PWM_BITS-1:0];
      else
         return tgt;
   endfunction

   // Reverse swaps the bridge polarity; STOP stays all-off either way.
   function automatic logic [3:0] hbCode(input patT p, input logic f);
      logic [3:0] raw;
      unique case (p)
         P_STRAIGHT: raw = 4'b0101;
         P_LEFT:     raw = 4'b0110;
         P_RIGHT:    raw = 4'b1001;
         default:    raw = 4'b0000;
      endcase
      return (f || p == P_STOP) ? raw : ~raw;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DRIVE;
         savedState <= DRIVE;
         inTurn     <= 1'b0;
         turnTimer  <= '0;
         tgtA       <= '0;
         tgtB       <= '0;
         pat        <= P_STOP;
         fwd        <= 1'b1;
      end else begin
         state      <= nextState;
         savedState <= nextSaved;
         inTurn     <= nextInTurn;
         turnTimer  <= nextTimer;
         tgtA       <= nextTgtA;
         tgtB       <= nextTgtB;
         pat        <= nextPat;
         fwd        <= nextFwd;
      end
   end

   always_comb begin
      nextState  = state;
      nextSaved  = savedState;
      nextInTurn = inTurn;
      nextTimer  = turnTimer;
      nextTgtA   = tgtA;
      nextTgtB   = tgtB;
      nextPat    = pat;
      nextFwd    = fwd;
      unique case (state)
         DRIVE: begin
            if (!col_detect_n) begin
               nextState = COLLISION;
               nextSaved = DRIVE;
            end else if (dir_control[3:2] == 2'b11) begin
               nextState  = JUNCTION;
               nextInTurn = 1'b0;
               nextTgtA   = '0;
               nextTgtB   = '0;
               nextPat    = P_STOP;
            end else begin
               case (dir_control)
                  4'b0000: begin
                     nextTgtA = duty_full;
                     nextTgtB = duty_full;
                     nextPat  = P_STRAIGHT;
                  end
                  4'b0101: begin
                     nextTgtA = duty_veer;
                     nextTgtB = duty_full;
                     nextPat  = P_STRAIGHT;
                  end
                  4'b1001: begin
                     nextTgtA = duty_full;
                     nextTgtB = duty_veer;
                     nextPat  = P_STRAIGHT;
                  end
                  4'b0110: begin
                     nextTgtA = duty_veer;
                     nextTgtB = duty_hard;
                     nextPat  = P_LEFT;
                  end
                  4'b1010: begin
                     nextTgtA = duty_hard;
                     nextTgtB = duty_veer;
                     nextPat  = P_RIGHT;
                  end
                  4'b0111: begin
                     nextTgtA = duty_pivot_slow;
                     nextTgtB = duty_pivot_fast;
                     nextPat  = P_LEFT;
                  end
                  4'b1011: begin
                     nextTgtA = duty_pivot_fast;
                     nextTgtB = duty_pivot_slow;
                     nextPat  = P_RIGHT;
                  end
                  default: ;
               endcase
            end
         end
         // Timer and sub-state are left alone so a pivot resumes.
         COLLISION: begin
            if (col_detect_n)
               nextState = savedState;
         end
         JUNCTION: begin
            if (!col_detect_n) begin
               nextState = COLLISION;
               nextSaved = JUNCTION;
            end else if (inTurn) begin
               if (turnTimer == TW'(TURN_CYCLES - 1)) begin
                  nextTimer  = '0;
                  nextInTurn = 1'b0;
                  nextState  = DRIVE;
               end else begin
                  nextTimer = turnTimer + 1'b1;
               end
            end else if (jcmd_valid) begin
               case (jcmd)
                  3'd0: nextState = DRIVE;
                  3'd1: begin
                     nextTimer  = '0;
                     nextInTurn = 1'b1;
                     nextTgtA   = duty_pivot_slow;
                     nextTgtB   = duty_pivot_fast;
                     nextPat    = P_LEFT;
                  end
                  3'd2: begin
                     nextTimer  = '0;
                     nextInTurn = 1'b1;
                     nextTgtA   = duty_pivot_fast;
                     nextTgtB   = duty_pivot_slow;
                     nextPat    = P_RIGHT;
                  end
                  3'd3: begin
                     nextFwd   = ~fwd;
                     nextState = DRIVE;
                  end
                  3'd4: begin
                     nextState = HALT;
                     nextTgtA  = '0;
                     nextTgtB  = '0;
                     nextPat   = P_STOP;
                  end
                  default: ;
               endcase
            end
         end
         HALT: begin
            nextTgtA = '0;
            nextTgtB = '0;
            nextPat  = P_STOP;
         end
         default: nextState = DRIVE;
      endcase
   end

   always_comb begin
      jcmd_ready  = (state == JUNCTION) && !inTurn;
      tone_enable = (state == JUNCTION) && !inTurn;
      turn_busy   = (state == JUNCTION) && inTurn;
      drive_state = state;
      direction   = fwd;
   end

   assign rampTick = (rampCnt == RW'(RAMP_DIV - 1));
   assign killDuty = (nextState == COLLISION) || (nextState == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         actA    <= '0;
         actB    <= '0;
         pwmCnt  <= '0;
         rampCnt <= '0;
         hb_in   <= 4'b0000;
         hb_en_a <= 1'b0;
         hb_en_b <= 1'b0;
      end else begin
         pwmCnt  <= pwmCnt + 1'b1;
         rampCnt <= rampTick ? '0 : rampCnt + 1'b1;
         actA    <= killDuty ? '0 : rampTo(actA, nextTgtA, rampTick);
         actB    <= killDuty ? '0 : rampTo(actB, nextTgtB, rampTick);
         hb_in   <= hbCode(nextPat, nextFwd);
         hb_en_a <= (pwmCnt < actA);
         hb_en_b <= (pwmCnt < actB);
      end
   end

endmodule
